// File: rtl/conv3x3_sched_pkg.sv
// Shared types and packing helpers for the 3x3 convolution sequencer.
// Tap (row,col) of a window sits at bit offset (row*3+col)*bits, row 0 being the oldest row.
package conv3x3_sched_pkg;

   localparam int unsigned KERN_TAPS = 9;
   localparam int unsigned W_BITS    = 8;
   localparam int unsigned RES_BITS  = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_K,
      RUN,
      DRAIN,
      DONE
   } state_t;

   function automatic int unsigned pix_lsb(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned bits);
      return (row * 3 + col) * bits;
   endfunction

   function automatic int unsigned kern_lsb(input int unsigned idx);
      return idx * W_BITS;
   endfunction

endpackage

// File: rtl/conv3x3_line_buf.sv
// Two-row line buffer plus 3x3 sliding window; flags the pixel that completes a window
// and registers the packed window (p00 at LSBs .. p22 at MSBs) one cycle later.
module conv3x3_line_buf
   import conv3x3_sched_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned IMG_W     = 8,
   parameter int unsigned XB        = 3,
   parameter int unsigned YB        = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   input  logic [XB-1:0]            i_x,
   input  logic [YB-1:0]            i_y,
   input  logic [DATA_BITS-1:0]     i_pix,
   output logic                     o_complete,
   output logic                     o_win_valid,
   output logic [9*DATA_BITS-1:0]   o_win
);

   logic [DATA_BITS-1:0]   r_row1 [IMG_W];
   logic [DATA_BITS-1:0]   r_row2 [IMG_W];
   logic [DATA_BITS-1:0]   r_c0   [3];
   logic [DATA_BITS-1:0]   r_c1   [3];
   logic [DATA_BITS-1:0]   w_col  [3];
   logic [9*DATA_BITS-1:0] w_win;

   always_comb begin
      w_col[0]   = r_row2[i_x];
      w_col[1]   = r_row1[i_x];
      w_col[2]   = i_pix;
      o_complete = i_valid && (i_x >= XB'(2)) && (i_y >= YB'(2));
      w_win      = '0;
      for (int unsigned r = 0; r < 3; r++) begin
         w_win[pix_lsb(r, 0, DATA_BITS) +: DATA_BITS] = r_c0[r];
         w_win[pix_lsb(r, 1, DATA_BITS) +: DATA_BITS] = r_c1[r];
         w_win[pix_lsb(r, 2, DATA_BITS) +: DATA_BITS] = w_col[r];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_win_valid <= 1'b0;
         o_win       <= '0;
         for (int unsigned i = 0; i < IMG_W; i++) begin
            r_row1[i] <= '0;
            r_row2[i] <= '0;
         end
         for (int unsigned r = 0; r < 3; r++) begin
            r_c0[r] <= '0;
            r_c1[r] <= '0;
         end
      end else begin
         o_win_valid <= o_complete;
         if (o_complete) begin
            o_win <= w_win;
         end
         if (i_valid) begin
            r_row2[i_x] <= r_row1[i_x];
            r_row1[i_x] <= i_pix;
            // Column history restarts at x=0 so windows never straddle two rows.
            for (int unsigned r = 0; r < 3; r++) begin
               r_c0[r] <= (i_x == '0) ? '0 : r_c1[r];
               r_c1[r] <= w_col[r];
            end
         end
      end
   end

endmodule

// File: rtl/conv3x3_sched.sv
// 3x3 convolution sequencer: kernel load, credit-limited pixel streaming, result FIFO.
// Define CONV3X3_SCHED_RELU_EN to clamp negative results to zero at the FIFO output.
module conv3x3_sched
   import conv3x3_sched_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned IMG_W      = 8,
   parameter int unsigned IMG_H      = 8,
   parameter int unsigned ADDR_BITS  = 16,
   parameter int unsigned RBUF_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic                            w_rd_en,
   output logic [3:0]                      w_addr,
   input  logic [W_BITS-1:0]               w_data,
   output logic                            px_rd_en,
   output logic [ADDR_BITS-1:0]            px_addr,
   input  logic [DATA_BITS-1:0]            px_data,
   output logic                            conv_valid,
   output logic [9*DATA_BITS-1:0]          conv_pix,
   output logic [KERN_TAPS*W_BITS-1:0]     conv_kern,
   input  logic [RES_BITS-1:0]             conv_result,
   input  logic                            conv_rvalid,
   output logic [RES_BITS-1:0]             res_data,
   output logic                            res_valid,
   input  logic                            res_ready
);

   localparam int unsigned XB = $clog2(IMG_W);
   localparam int unsigned YB = $clog2(IMG_H);
   localparam int unsigned CB = $clog2(RBUF_DEPTH + 1);
   localparam int unsigned PB = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

   localparam logic [XB-1:0]        X_LAST   = XB'(IMG_W - 1);
   localparam logic [YB-1:0]        Y_LAST   = YB'(IMG_H - 1);
   localparam logic [ADDR_BITS-1:0] N_RES_M1 = ADDR_BITS'((IMG_W - 2) * (IMG_H - 2) - 1);
   localparam logic [CB-1:0]        DEPTH    = CB'(RBUF_DEPTH);
   localparam logic [PB-1:0]        PTR_LAST = PB'(RBUF_DEPTH - 1);
   localparam logic [3:0]           K_LAST   = 4'(KERN_TAPS - 1);

   state_t                r_state;
   logic [XB-1:0]         r_rd_x, r_iss_x, r_px_x;
   logic [YB-1:0]         r_rd_y, r_iss_y, r_px_y;
   logic [ADDR_BITS-1:0]  r_rd_addr;
   logic [ADDR_BITS-1:0]  r_pop_cnt;
   logic                  r_px_pend;
   logic                  r_wcap_en;
   logic [3:0]            r_wcap_idx;
   logic [KERN_TAPS*W_BITS-1:0] r_kern;
   logic [CB-1:0]         r_used;
   logic [CB-1:0]         r_count;
   logic [PB-1:0]         r_wr_ptr, r_rd_ptr;
   logic [RES_BITS-1:0]   r_fifo [RBUF_DEPTH];

   logic                  w_issue, w_pop, w_push, w_free_arr, w_last_rd, w_complete;
   logic [RES_BITS-1:0]   w_head;

   always_comb begin
      w_issue    = (r_state == RUN) && (r_used < DEPTH);
      w_push     = conv_rvalid && ((r_state == RUN) || (r_state == DRAIN));
      w_free_arr = r_px_pend && !w_complete;
      w_last_rd  = (r_rd_x == X_LAST) && (r_rd_y == Y_LAST);
      res_valid  = (r_count != '0);
      w_pop      = res_valid && res_ready;
      w_head     = r_fifo[r_rd_ptr];
`ifdef CONV3X3_SCHED_RELU_EN
      res_data   = w_head[RES_BITS-1] ? '0 : w_head;
`else
      res_data   = w_head;
`endif
      conv_kern  = r_kern;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         w_rd_en   <= 1'b0;
         w_addr    <= '0;
         px_rd_en  <= 1'b0;
         px_addr   <= '0;
         r_rd_x    <= '0;
         r_rd_y    <= '0;
         r_iss_x   <= '0;
         r_iss_y   <= '0;
         r_rd_addr <= '0;
         r_pop_cnt <= '0;
      end else begin
         done     <= 1'b0;
         px_rd_en <= 1'b0;
         if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state   <= LOAD_K;
                  busy      <= 1'b1;
                  w_rd_en   <= 1'b1;
                  w_addr    <= '0;
                  r_rd_x    <= '0;
                  r_rd_y    <= '0;
                  r_rd_addr <= '0;
                  r_pop_cnt <= '0;
               end
            end
            LOAD_K: begin
               if (w_addr == K_LAST) begin
                  w_rd_en <= 1'b0;
                  r_state <= RUN;
               end else begin
                  w_addr <= w_addr + 1'b1;
               end
            end
            RUN: begin
               if (w_issue) begin
                  px_rd_en  <= 1'b1;
                  px_addr   <= r_rd_addr;
                  r_iss_x   <= r_rd_x;
                  r_iss_y   <= r_rd_y;
                  r_rd_addr <= r_rd_addr + 1'b1;
                  if (r_rd_x == X_LAST) begin
                     r_rd_x <= '0;
                     r_rd_y <= r_rd_y + 1'b1;
                  end else begin
                     r_rd_x <= r_rd_x + 1'b1;
                  end
                  if (w_last_rd) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_pop && (r_pop_cnt == N_RES_M1)) begin
                  r_state <= DONE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Window pixels keep their credit until the result leaves the FIFO, which bounds occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_px_pend  <= 1'b0;
         r_px_x     <= '0;
         r_px_y     <= '0;
         r_wcap_en  <= 1'b0;
         r_wcap_idx <= '0;
         r_kern     <= '0;
         r_used     <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         for (int unsigned i = 0; i < RBUF_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
      end else begin
         r_px_pend  <= px_rd_en;
         r_px_x     <= r_iss_x;
         r_px_y     <= r_iss_y;
         r_wcap_en  <= w_rd_en;
         r_wcap_idx <= w_addr;
         if (r_wcap_en) begin
            r_kern[kern_lsb(32'(r_wcap_idx)) +: W_BITS] <= w_data;
         end
         r_used  <= r_used + CB'(w_issue) - CB'(w_free_arr) - CB'(w_pop);
         r_count <= r_count + CB'(w_push) - CB'(w_pop);
         if (w_push) begin
            r_fifo[r_wr_ptr] <= conv_result;
            r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push && !w_pop) begin
         assert (r_count < DEPTH);
      end
   end

   conv3x3_line_buf #(
      .DATA_BITS (DATA_BITS),
      .IMG_W     (IMG_W),
      .XB        (XB),
      .YB        (YB)
   ) u_line_buf (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (r_px_pend),
      .i_x         (r_px_x),
      .i_y         (r_px_y),
      .i_pix       (px_data),
      .o_complete  (w_complete),
      .o_win_valid (conv_valid),
      .o_win       (conv_pix)
   );

endmodule

// File: tb/tb_conv3x3_sched.sv
// Self-checking bench for conv3x3_sched: memory/engine responders plus a direct 3x3 convolution reference.
module tb_conv3x3_sched;

   localparam int W    = 6;
   localparam int H    = 5;
   localparam int NPIX = W * H;
   localparam int NRES = (W - 2) * (H - 2);
   localparam int DB   = 8;
   localparam int AB   = 16;

   logic           clk = 1'b0;
   logic           rst, start, busy, done;
   logic           w_rd_en;
   logic [3:0]     w_addr;
   logic [7:0]     w_data;
   logic           px_rd_en;
   logic [AB-1:0]  px_addr;
   logic [DB-1:0]  px_data;
   logic           conv_valid;
   logic [9*DB-1:0] conv_pix;
   logic [71:0]    conv_kern;
   logic [31:0]    conv_result;
   logic           conv_rvalid = 1'b0;
   logic [31:0]    res_data;
   logic           res_valid, res_ready;

   int total = 0;
   int bad   = 0;
   logic [7:0]  kmem [9];
   logic [7:0]  pmem [NPIX];
   logic [31:0] expq [$];
   logic [31:0] got  [$];

   conv3x3_sched #(
      .DATA_BITS  (DB),
      .IMG_W      (W),
      .IMG_H      (H),
      .ADDR_BITS  (AB),
      .RBUF_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .w_rd_en     (w_rd_en),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .px_rd_en    (px_rd_en),
      .px_addr     (px_addr),
      .px_data     (px_data),
      .conv_valid  (conv_valid),
      .conv_pix    (conv_pix),
      .conv_kern   (conv_kern),
      .conv_result (conv_result),
      .conv_rvalid (conv_rvalid),
      .res_data    (res_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] engine(input logic [71:0] p, input logic [71:0] k);
      int s = 0;
      for (int i = 0; i < 9; i++) begin
         int a = int'($signed(p[8*i +: 8]));
         int b = int'($signed(k[8*i +: 8]));
         s += a * b;
      end
      return s;
   endfunction

   // Memories answer one cycle after the strobe; the engine answers one cycle after conv_valid.
   always @(posedge clk) begin
      if (w_rd_en && w_addr < 4'd9) w_data <= kmem[w_addr];
      if (px_rd_en && px_addr < AB'(NPIX)) px_data <= pmem[px_addr];
      conv_rvalid <= conv_valid;
      if (conv_valid) conv_result <= engine(conv_pix, conv_kern);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_win(input logic [AB-1:0] a);
      int v = int'(a);
      return ((v % W) >= 2) && ((v / W) >= 2);
   endfunction

   task automatic build_exp();
      expq.delete();
      for (int y = 2; y < H; y++) begin
         for (int x = 2; x < W; x++) begin
            int s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += int'($signed(pmem[(y-2+i)*W + (x-2+j)])) * int'($signed(kmem[i*3+j]));
`ifdef CONV3X3_SCHED_RELU_EN
            if (s < 0) s = 0;
`endif
            expq.push_back(s);
         end
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},     busy, 0);
      chk({tag, "_done"},     done, 0);
      chk({tag, "_w_rd_en"},  w_rd_en, 0);
      chk({tag, "_px_rd_en"}, px_rd_en, 0);
      chk({tag, "_conv_v"},   conv_valid, 0);
      chk({tag, "_res_v"},    res_valid, 0);
      chk({tag, "_w_addr"},   w_addr, 0);
      chk({tag, "_px_addr"},  px_addr, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_pix0"},     conv_pix == '0, 1);
      chk({tag, "_kern0"},    conv_kern == '0, 1);
   endtask

   // rmode 1 = random ready; stall_at/stall_len force ready low; abort_at resets after that many results.
   task automatic run_pass(input string tag, input int rmode, input int stall_at, input int stall_len,
                           input int abort_at, input int busy_start_at);
      int cyc = 0, n_conv = 0, issued = 0, freed = 0, popped = 0, held = 0, max_held = 0;
      int first_rd = -1, once = 0;
      int hits [NPIX];
      bit pend_nw = 0, prev_stall = 0, done_seen = 0;
      logic [31:0] prev_data = '0;
      for (int i = 0; i < NPIX; i++) hits[i] = 0;
      got.delete();
      build_exp();
      @(negedge clk);
      start = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_on"}, busy, 1);
      chk({tag, "_wload0"}, {w_rd_en, w_addr}, {1'b1, 4'd0});
      while (!done_seen && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = (cyc == busy_start_at);
         if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len) res_ready = 1'b0;
         else if (rmode == 1) res_ready = ($urandom_range(0, 3) != 0);
         else res_ready = 1'b1;
         if (px_rd_en) begin
            if (px_addr < AB'(NPIX)) hits[px_addr]++;
            issued++;
         end
         freed += int'(pend_nw);
         pend_nw = px_rd_en && !is_win(px_addr);
         held = issued - freed - popped;
         if (held > max_held) max_held = held;
         if (conv_valid) n_conv++;
         if (prev_stall) begin
            chk({tag, "_hold_v"}, res_valid, 1);
            chk({tag, "_hold_d"}, res_data, prev_data);
         end
         if (res_valid && res_ready) begin
            got.push_back(res_data);
            popped++;
         end
         prev_stall = res_valid && !res_ready;
         prev_data = res_data;
         if (stall_at >= 0 && first_rd < 0 && cyc >= stall_at + stall_len && px_rd_en) first_rd = cyc;
         if (done) begin
            done_seen = 1;
            chk({tag, "_busy_at_done"}, busy, 0);
         end
         if (abort_at >= 0 && got.size() == abort_at) begin
            rst = 1'b1;
            start = 1'b0;
            @(negedge clk);
            chk_idle({tag, "_rst"});
            rst = 1'b0;
            return;
         end
      end
      chk({tag, "_done_seen"}, done_seen, 1);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_no_extra"}, res_valid, 0);
      chk({tag, "_count"}, got.size(), expq.size());
      for (int i = 0; i < got.size() && i < expq.size(); i++) chk({tag, "_res"}, got[i], expq[i]);
      chk({tag, "_nconv"}, n_conv, NRES);
      for (int i = 0; i < NPIX; i++) if (hits[i] == 1) once++;
      chk({tag, "_addr_once"}, once, NPIX);
      chk({tag, "_reads"}, issued, NPIX);
      chk({tag, "_credit_max"}, max_held <= 4, 1);
      if (stall_at >= 0) begin
         chk({tag, "_credit_full"}, max_held, 4);
         chk({tag, "_resume"}, first_rd >= 0 && first_rd <= stall_at + stall_len + 4, 1);
      end
   endtask

   initial begin
      res_ready = 1'b0;
      rst = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 9; i++) kmem[i] = 8'd0;
      for (int i = 0; i < NPIX; i++) pmem[i] = 8'd0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_w_rd", w_rd_en, 0);
         chk("rst_px_rd", px_rd_en, 0);
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk_idle("post_rst");
      @(negedge clk);
      chk("start_in_rst_ignored", {busy, w_rd_en}, 2'b00);

      // identity kernel, px = y*W + x
      kmem[4] = 8'd1;
      for (int i = 0; i < NPIX; i++) pmem[i] = 8'(i);
      run_pass("ident", 0, -1, 0, -1, -1);
      if (got.size() == NRES) begin
         chk("ident_first", got[0], 32'd7);
         chk("ident_last", got[NRES-1], 32'd22);
      end

      // all-ones kernel and image
      for (int i = 0; i < 9; i++) kmem[i] = 8'd1;
      for (int i = 0; i < NPIX; i++) pmem[i] = 8'd1;
      run_pass("ones", 0, -1, 0, -1, -1);
      if (got.size() > 0) chk("ones_val", got[0], 32'd9);

      // backpressure on the identity case
      for (int i = 0; i < 9; i++) kmem[i] = 8'd0;
      kmem[4] = 8'd1;
      for (int i = 0; i < NPIX; i++) pmem[i] = 8'(i);
      run_pass("stall", 0, 20, 20, -1, -1);

      // negative results
      for (int i = 0; i < 9; i++) kmem[i] = 8'hFF;
      for (int i = 0; i < NPIX; i++) pmem[i] = 8'd10;
      run_pass("neg", 0, -1, 0, -1, -1);
`ifdef CONV3X3_SCHED_RELU_EN
      if (got.size() > 0) chk("neg_val", got[0], 32'd0);
`else
      if (got.size() > 0) chk("neg_val", got[0], 32'hFFFF_FFA6);
`endif

      // reset at result 2, then a clean pass with a start pulse while busy
      for (int i = 0; i < 9; i++) kmem[i] = 8'd1;
      for (int i = 0; i < NPIX; i++) pmem[i] = 8'd1;
      run_pass("abort", 0, -1, 0, 2, -1);
      repeat (3) @(negedge clk);
      chk("abort_idle", {busy, res_valid, px_rd_en}, 3'b000);
      run_pass("restart", 0, -1, 0, -1, 25);
      repeat (3) @(negedge clk);
      chk("restart_no_rerun", {busy, w_rd_en}, 2'b00);

      // randomized kernels and images with random backpressure
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 9; i++) kmem[i] = 8'($urandom_range(0, 255));
         for (int i = 0; i < NPIX; i++) pmem[i] = 8'($urandom_range(0, 255));
         run_pass("rand", 1, -1, 0, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
